oflow_score_board: RTL and testbench
====================================

OFLOW_SCORE_BOARD -- requirements
Module: oflow_score_board

Interface
REQ-001 Parameter NUM_PE, default 8, number of PEs (columns); PE_LEN = $clog2(NUM_PE).
REQ-002 Parameter MAX_ROWS, default 32, number of rows per column; ROW_LEN = $clog2(MAX_ROWS).
REQ-003 Parameters SCORE_LEN, default 16, and ID_LEN, default 12: widths of the score and id fields.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset_N  in  1  reset, asynchronous, active-low.
REQ-006 clear_sb  in  1  single-cycle pulse that starts a new frame.
REQ-007 fill_done  in  1  single-cycle pulse; all PE writes for the frame are complete.
REQ-008 pe_wr_valid  in  NUM_PE  per-PE candidate write strobe.
REQ-009 pe_wr_row  in  NUM_PE*ROW_LEN  per-PE target row, packed with PE0 in the LSBs.
REQ-010 pe_wr_score  in  NUM_PE*SCORE_LEN  per-PE candidate score (lower is better), packed.
REQ-011 pe_wr_id  in  NUM_PE*ID_LEN  per-PE candidate id, packed.
REQ-012 start_cr  out  1  single-cycle pulse to the conflict resolver.
REQ-013 done_cr  in  1  conflict resolver finished.
REQ-014 row_sel, pe_sel  in  ROW_LEN, PE_LEN  conflict-resolver read address.
REQ-015 score_to_cr, id_to_cr  out  SCORE_LEN, ID_LEN  selected candidate at the read address.
REQ-016 write_to_pointer  in  1  pointer write strobe from the resolver.
REQ-017 row_to_change, pe_to_change  in  ROW_LEN, PE_LEN  pointer write address.
REQ-018 data_to_score_board  in  1  new pointer value: 0 = best candidate, 1 = fallback.
REQ-019 sb_state  out  2  current FSM state, for debug.
REQ-020 frame_done  out  1  single-cycle pulse when the frame's conflict resolution is complete.

Function
REQ-021 Each entry (pe,row) SHALL hold cand0/cand1 {score,id}, valid0/valid1, and a 1-bit ptr.
REQ-022 FSM states: IDLE=0, FILL=1, CR=2, DONE=3.
- IDLE to FILL on clear_sb.
- FILL to CR on fill_done, with start_cr high for exactly that transition cycle (registered, 1 cycle after fill_done).
- CR to DONE on done_cr.
- DONE to IDLE unconditionally after 1 cycle, with frame_done high while in DONE.
REQ-023 clear_sb in any state SHALL, in the same edge, invalidate all entries, zero all ptr, and enter FILL; clear_sb takes priority over every other event.
REQ-024 PE writes SHALL be accepted only in FILL; in other states they are ignored.
REQ-025 Writes with row >= MAX_ROWS SHALL be ignored.
REQ-026 Insertion for pe p with pe_wr_valid[p]=1, one per cycle per PE, 1-cycle latency:
- If !valid0 or new<cand0.score: cand1 takes old cand0 (valid1 takes old valid0), and cand0 takes new.
- Else if !valid1 or new<cand1.score: cand1 takes new.
- Else: drop the write.
- Ties SHALL keep the existing candidate (strict less-than).
REQ-027 PEs own disjoint columns, so all NUM_PE writes in the same cycle SHALL complete independently.
REQ-028 Read path SHALL be combinational. The selected candidate is cand[ptr] of entry (pe_sel,row_sel). If that candidate is invalid, the outputs SHALL be score all-ones and id 0.
REQ-029 Pointer write:
- Accepted only in CR when write_to_pointer=1.
- ptr(pe_to_change,row_to_change) takes data_to_score_board on the next edge.
- Out-of-range address: ignored.
REQ-030 A read of the same entry in the cycle after a pointer write SHALL reflect the new ptr.
REQ-031 fill_done outside FILL and done_cr outside CR SHALL be ignored.

Reset
REQ-032 While reset_N=0 (asynchronous):
- state=IDLE.
- All valid bits 0, all ptr 0.
- start_cr=0, frame_done=0, sb_state=0.
- Read outputs equal the empty-entry values: score all-ones, id 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame; no start_cr or frame_done pulse is produced afterwards until a new clear_sb.

Verification
REQ-034 clear_sb; PE2 writes row 5 with scores 40, 20, 30 (ids 1, 2, 3) -> cand0={20,2}, cand1={30,3}; read (2,5) gives 20/2.
REQ-035 FILL; PE0 writes score 10 to row 0 twice (ids 7, 9) -> cand0 id=7, cand1 id=9 (tie keeps the existing entry).
REQ-036 fill_done -> start_cr is a single pulse 1 cycle later; write_to_pointer (pe2,row5,1) -> next cycle read (2,5) gives 30/3; a pointer write to an empty fallback reads FFFF/0.
REQ-037 PE writes during CR, and pointer writes during FILL -> no change to any entry.
REQ-038 done_cr -> frame_done pulses for 1 cycle, then state=IDLE; clear_sb mid-CR -> all entries empty, state=FILL, no frame_done.
REQ-039 reset_N low mid-FILL, then released -> all outputs at reset values; fill_done ignored until the next clear_sb.

Source files
------------

// File: rtl/oflow_score_board_if.sv
// rtl/oflow_score_board_if.sv - PE write and conflict-resolver buses of the overflow score board
interface oflow_score_board_if #(
  parameter int NUM_PE    = 8,
  parameter int MAX_ROWS  = 32,
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12
);
  localparam int PE_LEN  = $clog2(NUM_PE);
  localparam int ROW_LEN = $clog2(MAX_ROWS);

  logic [NUM_PE-1:0]           pe_wr_valid;
  logic [NUM_PE*ROW_LEN-1:0]   pe_wr_row;
  logic [NUM_PE*SCORE_LEN-1:0] pe_wr_score;
  logic [NUM_PE*ID_LEN-1:0]    pe_wr_id;

  logic [ROW_LEN-1:0]   row_sel;
  logic [PE_LEN-1:0]    pe_sel;
  logic [SCORE_LEN-1:0] score_to_cr;
  logic [ID_LEN-1:0]    id_to_cr;

  logic                 write_to_pointer;
  logic [ROW_LEN-1:0]   row_to_change;
  logic [PE_LEN-1:0]    pe_to_change;
  logic                 data_to_score_board;

  modport master (
    output pe_wr_valid, pe_wr_row, pe_wr_score, pe_wr_id,
    output row_sel, pe_sel, write_to_pointer, row_to_change, pe_to_change, data_to_score_board,
    input  score_to_cr, id_to_cr
  );

  modport slave (
    input  pe_wr_valid, pe_wr_row, pe_wr_score, pe_wr_id,
    input  row_sel, pe_sel, write_to_pointer, row_to_change, pe_to_change, data_to_score_board,
    output score_to_cr, id_to_cr
  );
endinterface

// File: rtl/oflow_score_board.sv
// rtl/oflow_score_board.sv - per-PE/row best-two candidate store with resolver pointer and frame FSM
module oflow_score_board #(
  parameter int NUM_PE    = 8,
  parameter int MAX_ROWS  = 32,
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12
) (
  input  logic       clk,
  input  logic       reset_N,
  input  logic       clear_sb,
  input  logic       fill_done,
  input  logic       done_cr,
  output logic       start_cr,
  output logic       frame_done,
  output logic [1:0] sb_state,
  oflow_score_board_if.slave sb_if
);
  localparam int PE_LEN  = $clog2(NUM_PE);
  localparam int ROW_LEN = $clog2(MAX_ROWS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_CR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;

  logic [MAX_ROWS-1:0]  valid0 [NUM_PE];
  logic [MAX_ROWS-1:0]  valid1 [NUM_PE];
  logic [MAX_ROWS-1:0]  ptr    [NUM_PE];
  logic [SCORE_LEN-1:0] c0_score [NUM_PE][MAX_ROWS];
  logic [SCORE_LEN-1:0] c1_score [NUM_PE][MAX_ROWS];
  logic [ID_LEN-1:0]    c0_id    [NUM_PE][MAX_ROWS];
  logic [ID_LEN-1:0]    c1_id    [NUM_PE][MAX_ROWS];

  logic [ROW_LEN-1:0]   w_row   [NUM_PE];
  logic [SCORE_LEN-1:0] w_score [NUM_PE];
  logic [ID_LEN-1:0]    w_id    [NUM_PE];
  logic [NUM_PE-1:0]    ins0;
  logic [NUM_PE-1:0]    ins1;
  logic                 ptr_wr;

  // Each PE owns its column, so insertion decisions are independent per PE.
  always_comb begin
    ins0 = '0;
    ins1 = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      w_row[p]   = sb_if.pe_wr_row[p*ROW_LEN +: ROW_LEN];
      w_score[p] = sb_if.pe_wr_score[p*SCORE_LEN +: SCORE_LEN];
      w_id[p]    = sb_if.pe_wr_id[p*ID_LEN +: ID_LEN];
      if (state == S_FILL && !clear_sb && sb_if.pe_wr_valid[p] && 32'(w_row[p]) < MAX_ROWS) begin
        if (!valid0[p][w_row[p]] || w_score[p] < c0_score[p][w_row[p]])
          ins0[p] = 1'b1;
        else if (!valid1[p][w_row[p]] || w_score[p] < c1_score[p][w_row[p]])
          ins1[p] = 1'b1;
      end
    end
  end

  assign ptr_wr = state == S_CR && !clear_sb && sb_if.write_to_pointer &&
                  32'(sb_if.pe_to_change) < NUM_PE && 32'(sb_if.row_to_change) < MAX_ROWS;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int p = 0; p < NUM_PE; p++) begin
        valid0[p] <= '0;
        valid1[p] <= '0;
        ptr[p]    <= '0;
      end
    end else if (clear_sb) begin
      for (int p = 0; p < NUM_PE; p++) begin
        valid0[p] <= '0;
        valid1[p] <= '0;
        ptr[p]    <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PE; p++) begin
        if (ins0[p]) begin
          valid1[p][w_row[p]] <= valid0[p][w_row[p]];
          valid0[p][w_row[p]] <= 1'b1;
        end else if (ins1[p]) begin
          valid1[p][w_row[p]] <= 1'b1;
        end
      end
      if (ptr_wr)
        ptr[sb_if.pe_to_change][sb_if.row_to_change] <= sb_if.data_to_score_board;
    end
  end

  // Candidate payload needs no reset: the valid bits qualify it.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PE; p++) begin
      if (ins0[p]) begin
        c1_score[p][w_row[p]] <= c0_score[p][w_row[p]];
        c1_id[p][w_row[p]]    <= c0_id[p][w_row[p]];
        c0_score[p][w_row[p]] <= w_score[p];
        c0_id[p][w_row[p]]    <= w_id[p];
      end else if (ins1[p]) begin
        c1_score[p][w_row[p]] <= w_score[p];
        c1_id[p][w_row[p]]    <= w_id[p];
      end
    end
  end

  always_comb begin
    sb_if.score_to_cr = '1;
    sb_if.id_to_cr    = '0;
    if (32'(sb_if.pe_sel) < NUM_PE && 32'(sb_if.row_sel) < MAX_ROWS) begin
      if (ptr[sb_if.pe_sel][sb_if.row_sel]) begin
        if (valid1[sb_if.pe_sel][sb_if.row_sel]) begin
          sb_if.score_to_cr = c1_score[sb_if.pe_sel][sb_if.row_sel];
          sb_if.id_to_cr    = c1_id[sb_if.pe_sel][sb_if.row_sel];
        end
      end else if (valid0[sb_if.pe_sel][sb_if.row_sel]) begin
        sb_if.score_to_cr = c0_score[sb_if.pe_sel][sb_if.row_sel];
        sb_if.id_to_cr    = c0_id[sb_if.pe_sel][sb_if.row_sel];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state    <= S_IDLE;
      start_cr <= 1'b0;
    end else begin
      start_cr <= 1'b0;
      if (clear_sb) begin
        state <= S_FILL;
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_FILL: if (fill_done) begin
            state    <= S_CR;
            start_cr <= 1'b1;
          end
          S_CR:   if (done_cr) state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign frame_done = state == S_DONE;
  assign sb_state   = state;
endmodule

// File: tb/tb_oflow_score_board.sv
// tb/tb_oflow_score_board.sv - randomized and directed bench for oflow_score_board
module tb_oflow_score_board;
  localparam int NUM_PE    = 8;
  localparam int MAX_ROWS  = 32;
  localparam int SCORE_LEN = 16;
  localparam int ID_LEN    = 12;
  localparam int PE_LEN    = $clog2(NUM_PE);
  localparam int ROW_LEN   = $clog2(MAX_ROWS);
  localparam int S_IDLE = 0, S_FILL = 1, S_CR = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic reset_N;
  logic clear_sb = 1'b0, fill_done = 1'b0, done_cr = 1'b0;
  logic start_cr, frame_done;
  logic [1:0] sb_state;

  oflow_score_board_if #(.NUM_PE(NUM_PE), .MAX_ROWS(MAX_ROWS), .SCORE_LEN(SCORE_LEN), .ID_LEN(ID_LEN)) sb_if ();

  oflow_score_board #(.NUM_PE(NUM_PE), .MAX_ROWS(MAX_ROWS), .SCORE_LEN(SCORE_LEN), .ID_LEN(ID_LEN)) dut (
    .clk(clk), .reset_N(reset_N), .clear_sb(clear_sb), .fill_done(fill_done), .done_cr(done_cr),
    .start_cr(start_cr), .frame_done(frame_done), .sb_state(sb_state), .sb_if(sb_if)
  );

  always #5 clk = ~clk;

  // Model: each entry is a list of at most two candidates, best first.
  int  m_cnt [NUM_PE][MAX_ROWS];
  int  m_sc  [NUM_PE][MAX_ROWS][2];
  int  m_id  [NUM_PE][MAX_ROWS][2];
  bit  m_ptr [NUM_PE][MAX_ROWS];
  int  m_state;
  bit  m_start;
  int  n_cmp = 0, n_fail = 0;
  bit  chk_en = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_clear();
    for (int p = 0; p < NUM_PE; p++)
      for (int r = 0; r < MAX_ROWS; r++) begin
        m_cnt[p][r] = 0;
        m_ptr[p][r] = 1'b0;
      end
  endfunction

  function automatic void model_reset();
    m_clear();
    m_state = S_IDLE;
    m_start = 1'b0;
  endfunction

  // Append the newcomer, stable-sort by score, keep the best two.
  function automatic void m_insert(int p, int r, int s, int id);
    int ls [3];
    int li [3];
    int n, t;
    n = m_cnt[p][r];
    for (int i = 0; i < n; i++) begin
      ls[i] = m_sc[p][r][i];
      li[i] = m_id[p][r][i];
    end
    ls[n] = s;
    li[n] = id;
    n++;
    for (int i = 1; i < n; i++)
      for (int j = i; j > 0; j--)
        if (ls[j] < ls[j-1]) begin
          t = ls[j]; ls[j] = ls[j-1]; ls[j-1] = t;
          t = li[j]; li[j] = li[j-1]; li[j-1] = t;
        end
    m_cnt[p][r] = (n > 2) ? 2 : n;
    for (int i = 0; i < m_cnt[p][r]; i++) begin
      m_sc[p][r][i] = ls[i];
      m_id[p][r][i] = li[i];
    end
  endfunction

  function automatic logic [SCORE_LEN+ID_LEN-1:0] m_read(int p, int r);
    int k;
    if (p >= NUM_PE || r >= MAX_ROWS) return {{SCORE_LEN{1'b1}}, {ID_LEN{1'b0}}};
    k = int'(m_ptr[p][r]);
    if (k < m_cnt[p][r]) return {SCORE_LEN'(m_sc[p][r][k]), ID_LEN'(m_id[p][r][k])};
    return {{SCORE_LEN{1'b1}}, {ID_LEN{1'b0}}};
  endfunction

  function automatic void model_step();
    int r;
    m_start = 1'b0;
    if (!reset_N) begin
      model_reset();
      return;
    end
    if (clear_sb) begin
      m_clear();
      m_state = S_FILL;
      return;
    end
    case (m_state)
      S_FILL: begin
        for (int p = 0; p < NUM_PE; p++)
          if (sb_if.pe_wr_valid[p]) begin
            r = int'(sb_if.pe_wr_row[p*ROW_LEN +: ROW_LEN]);
            if (r < MAX_ROWS)
              m_insert(p, r, int'(sb_if.pe_wr_score[p*SCORE_LEN +: SCORE_LEN]),
                       int'(sb_if.pe_wr_id[p*ID_LEN +: ID_LEN]));
          end
        if (fill_done) begin
          m_state = S_CR;
          m_start = 1'b1;
        end
      end
      S_CR: begin
        if (sb_if.write_to_pointer && int'(sb_if.pe_to_change) < NUM_PE && int'(sb_if.row_to_change) < MAX_ROWS)
          m_ptr[sb_if.pe_to_change][sb_if.row_to_change] = sb_if.data_to_score_board;
        if (done_cr) m_state = S_DONE;
      end
      S_DONE: m_state = S_IDLE;
      default: m_state = S_IDLE;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_state", 32'(sb_state), m_state);
      chk("start_cr", 32'(start_cr), 32'(m_start));
      chk("frame_done", 32'(frame_done), 32'(m_state == S_DONE));
      chk("score_to_cr", 32'(sb_if.score_to_cr),
          32'(m_read(int'(sb_if.pe_sel), int'(sb_if.row_sel)) >> ID_LEN));
      chk("id_to_cr", 32'(sb_if.id_to_cr),
          32'(m_read(int'(sb_if.pe_sel), int'(sb_if.row_sel)) & {ID_LEN{1'b1}}));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    clear_sb = 1'b0; fill_done = 1'b0; done_cr = 1'b0;
    sb_if.pe_wr_valid = '0; sb_if.pe_wr_row = '0; sb_if.pe_wr_score = '0; sb_if.pe_wr_id = '0;
    sb_if.row_sel = '0; sb_if.pe_sel = '0;
    sb_if.write_to_pointer = 1'b0; sb_if.row_to_change = '0; sb_if.pe_to_change = '0;
    sb_if.data_to_score_board = 1'b0;
  endtask

  task automatic rand_bus();
    sb_if.pe_wr_valid = NUM_PE'($urandom);
    for (int p = 0; p < NUM_PE; p++) begin
      sb_if.pe_wr_row[p*ROW_LEN +: ROW_LEN]       = ROW_LEN'($urandom_range(0, 3));
      sb_if.pe_wr_score[p*SCORE_LEN +: SCORE_LEN] = SCORE_LEN'($urandom_range(0, 15));
      sb_if.pe_wr_id[p*ID_LEN +: ID_LEN]          = ID_LEN'($urandom);
    end
    sb_if.row_sel = ROW_LEN'($urandom_range(0, 4));
    sb_if.pe_sel  = PE_LEN'($urandom);
    sb_if.write_to_pointer    = ($urandom_range(0, 2) == 0);
    sb_if.row_to_change       = ROW_LEN'($urandom_range(0, 4));
    sb_if.pe_to_change        = PE_LEN'($urandom);
    sb_if.data_to_score_board = 1'($urandom);
  endtask

  task automatic set_wr(int p, int r, int s, int id);
    sb_if.pe_wr_valid[p] = 1'b1;
    sb_if.pe_wr_row[p*ROW_LEN +: ROW_LEN]       = ROW_LEN'(r);
    sb_if.pe_wr_score[p*SCORE_LEN +: SCORE_LEN] = SCORE_LEN'(s);
    sb_if.pe_wr_id[p*ID_LEN +: ID_LEN]          = ID_LEN'(id);
  endtask

  task automatic set_ptr(int p, int r, bit d);
    sb_if.write_to_pointer = 1'b1;
    sb_if.pe_to_change = PE_LEN'(p);
    sb_if.row_to_change = ROW_LEN'(r);
    sb_if.data_to_score_board = d;
  endtask

  task automatic read_chk(string nm, int p, int r, int s, int id);
    sb_if.pe_sel = PE_LEN'(p);
    sb_if.row_sel = ROW_LEN'(r);
    #1;
    chk({nm, "_score"}, 32'(sb_if.score_to_cr), s);
    chk({nm, "_id"}, 32'(sb_if.id_to_cr), id);
  endtask

  initial begin
    quiet();
    reset_N = 1'b0;
    model_reset();
    chk_en = 1'b1;
    cycle();
    chk("rst_state", 32'(sb_state), 0);
    chk("rst_start", 32'(start_cr), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    read_chk("rst_read", 0, 0, 16'hFFFF, 0);
    reset_N = 1'b1;
    cycle();

    // Best-two insertion and tie handling
    clear_sb = 1'b1; cycle(); quiet();
    chk("fill_state", 32'(sb_state), 1);
    set_wr(2, 5, 40, 1); set_wr(0, 0, 10, 7); cycle(); quiet();
    set_wr(2, 5, 20, 2); set_wr(0, 0, 10, 9); cycle(); quiet();
    set_wr(2, 5, 30, 3); cycle(); quiet();
    read_chk("ins_2_5", 2, 5, 20, 2);
    read_chk("tie_0_0", 0, 0, 10, 7);
    chk("model_c1_2_5", 32'(m_sc[2][5][1]), 30);
    chk("model_tie_c1", 32'(m_id[0][0][1]), 9);

    fill_done = 1'b1; cycle(); quiet();
    chk("start_pulse", 32'(start_cr), 1);
    chk("cr_state", 32'(sb_state), 2);
    set_wr(2, 5, 1, 15); set_ptr(2, 5, 1'b1); cycle(); quiet();
    chk("start_single", 32'(start_cr), 0);
    read_chk("ptr_2_5", 2, 5, 30, 3);
    set_ptr(0, 0, 1'b1); cycle(); quiet();
    read_chk("ptr_0_0", 0, 0, 10, 9);
    set_ptr(3, 7, 1'b1); cycle(); quiet();
    read_chk("ptr_empty", 3, 7, 16'hFFFF, 0);
    set_ptr(2, 5, 1'b0); cycle(); quiet();
    read_chk("cr_wr_ignored", 2, 5, 20, 2);

    done_cr = 1'b1; cycle(); quiet();
    chk("frame_done_hi", 32'(frame_done), 1);
    chk("done_state", 32'(sb_state), 3);
    cycle();
    chk("frame_done_lo", 32'(frame_done), 0);
    chk("idle_state", 32'(sb_state), 0);

    // Pointer writes in FILL are ignored; clear_sb mid-CR aborts the frame
    clear_sb = 1'b1; cycle(); quiet();
    set_wr(1, 3, 5, 4); cycle(); quiet();
    set_wr(1, 3, 6, 8); set_ptr(1, 3, 1'b1); cycle(); quiet();
    read_chk("fill_ptr_ignored", 1, 3, 5, 4);
    fill_done = 1'b1; cycle(); quiet();
    clear_sb = 1'b1; cycle(); quiet();
    chk("clear_cr_state", 32'(sb_state), 1);
    read_chk("clear_cr_empty", 1, 3, 16'hFFFF, 0);
    cycle();
    chk("clear_cr_no_done", 32'(frame_done), 0);

    // Asynchronous reset mid-FILL
    set_wr(4, 2, 9, 9); cycle(); quiet();
    reset_N = 1'b0;
    model_reset();
    read_chk("async_rst_read", 4, 2, 16'hFFFF, 0);
    chk("async_rst_state", 32'(sb_state), 0);
    cycle();
    reset_N = 1'b1;
    cycle();
    fill_done = 1'b1; cycle(); quiet();
    chk("post_rst_fill_ignored", 32'(sb_state), 0);
    cycle();
    chk("post_rst_no_start", 32'(start_cr), 0);

    // Randomized frames with stray events
    for (int f = 0; f < 40; f++) begin
      rand_bus(); clear_sb = 1'b1; cycle(); quiet();
      repeat ($urandom_range(3, 12)) begin
        rand_bus();
        done_cr  = ($urandom_range(0, 7) == 0);
        clear_sb = ($urandom_range(0, 15) == 0);
        cycle();
      end
      clear_sb = 1'b0; done_cr = 1'b0;
      rand_bus(); fill_done = 1'b1; cycle(); fill_done = 1'b0;
      repeat ($urandom_range(3, 10)) begin
        rand_bus();
        fill_done = ($urandom_range(0, 7) == 0);
        cycle();
      end
      fill_done = 1'b0;
      rand_bus(); done_cr = 1'b1; cycle(); done_cr = 1'b0;
      rand_bus(); cycle();
      repeat (2) begin
        rand_bus();
        fill_done = ($urandom_range(0, 3) == 0);
        done_cr   = ($urandom_range(0, 3) == 0);
        cycle();
      end
      quiet();
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
